// File: rtl/n64_poll_sched_if.sv
// Signal bundle between the N64 poll scheduler and the tx/rx datapath.
// N64_POLL_STATS_EN adds the poll_cnt/err_cnt statistics outputs.
interface n64_poll_sched_if;
    logic        enable;
    logic        tx_busy;
    logic        rx_done;
    logic [31:0] rx_data;
    logic        tx_trigger;
    logic        rx_enable;
    logic [31:0] ctrl_state;
    logic        state_valid;
    logic        ctrl_present;
    logic        poll_err;
`ifdef N64_POLL_STATS_EN
    logic [15:0] poll_cnt;
    logic [15:0] err_cnt;

    modport master (
        output enable, tx_busy, rx_done, rx_data,
        input  tx_trigger, rx_enable, ctrl_state, state_valid, ctrl_present, poll_err,
        input  poll_cnt, err_cnt
    );
    modport slave (
        input  enable, tx_busy, rx_done, rx_data,
        output tx_trigger, rx_enable, ctrl_state, state_valid, ctrl_present, poll_err,
        output poll_cnt, err_cnt
    );
`else
    modport master (
        output enable, tx_busy, rx_done, rx_data,
        input  tx_trigger, rx_enable, ctrl_state, state_valid, ctrl_present, poll_err
    );
    modport slave (
        input  enable, tx_busy, rx_done, rx_data,
        output tx_trigger, rx_enable, ctrl_state, state_valid, ctrl_present, poll_err
    );
`endif
endinterface

// File: rtl/n64_poll_sched.sv
// Periodic N64 controller poll scheduler with tx/rx timeouts and bounded retries.
// N64_POLL_STATS_EN adds saturating poll_cnt/err_cnt counters.
module n64_poll_sched #(
    parameter int unsigned POLL_PERIOD = 2048,
    parameter int unsigned TRIG_LEN    = 4,
    parameter int unsigned TX_TIMEOUT  = 200,
    parameter int unsigned RX_TIMEOUT  = 600,
    parameter int unsigned MAX_RETRY   = 2
) (
    input logic              clk_4M,
    input logic              rst,
    n64_poll_sched_if.slave  bus
);
    localparam int unsigned TMax = (TX_TIMEOUT > RX_TIMEOUT) ? TX_TIMEOUT : RX_TIMEOUT;
    localparam int unsigned TW   = $clog2(TMax) + 1;
    localparam int unsigned PW   = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int unsigned RW   = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {StIdle, StTrig, StTxw, StRxw, StErr} state_e;

    state_e        state_q;
    logic [PW-1:0] period_q;
    logic [TW-1:0] timer_q;
    logic [RW-1:0] retry_q;
    logic          busy_seen_q;
    logic          rx_done_q;
    logic          tx_trigger_q;
    logic          rx_enable_q;
    logic [31:0]   ctrl_state_q;
    logic          state_valid_q;
    logic          ctrl_present_q;
    logic          poll_err_q;

    logic          tick;
    logic          rx_rise;
    logic [TW-1:0] timer_inc;

    assign tick      = (period_q == PW'(POLL_PERIOD - 1));
    assign rx_rise   = bus.rx_done & ~rx_done_q;
    // Timers saturate instead of wrapping.
    assign timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;

`ifdef N64_POLL_STATS_EN
    logic [15:0] poll_cnt_q;
    logic [15:0] err_cnt_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign bus.poll_cnt = poll_cnt_q;
    assign bus.err_cnt  = err_cnt_q;
`endif

    always_ff @(posedge clk_4M or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            period_q       <= '0;
            timer_q        <= '0;
            retry_q        <= '0;
            busy_seen_q    <= 1'b0;
            rx_done_q      <= 1'b0;
            tx_trigger_q   <= 1'b0;
            rx_enable_q    <= 1'b0;
            ctrl_state_q   <= '0;
            state_valid_q  <= 1'b0;
            ctrl_present_q <= 1'b0;
            poll_err_q     <= 1'b0;
`ifdef N64_POLL_STATS_EN
            poll_cnt_q     <= '0;
            err_cnt_q      <= '0;
`endif
        end else begin
            period_q      <= tick ? '0 : period_q + 1'b1;
            rx_done_q     <= bus.rx_done;
            state_valid_q <= 1'b0;
            poll_err_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (tick && bus.enable) begin
                        state_q      <= StTrig;
                        tx_trigger_q <= 1'b1;
                        timer_q      <= '0;
`ifdef N64_POLL_STATS_EN
                        poll_cnt_q   <= sat_inc16(poll_cnt_q);
`endif
                    end
                end
                StTrig: begin
                    if (timer_q == TW'(TRIG_LEN - 1)) begin
                        state_q      <= StTxw;
                        tx_trigger_q <= 1'b0;
                        timer_q      <= '0;
                        busy_seen_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                StTxw: begin
                    if (bus.tx_busy) busy_seen_q <= 1'b1;
                    if (busy_seen_q && !bus.tx_busy) begin
                        state_q     <= StRxw;
                        rx_enable_q <= 1'b1;
                        timer_q     <= '0;
                    end else if (timer_q == TW'(TX_TIMEOUT - 1)) begin
                        state_q   <= StErr;
`ifdef N64_POLL_STATS_EN
                        err_cnt_q <= sat_inc16(err_cnt_q);
`endif
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                StRxw: begin
                    // A reply completing on the timeout cycle still counts as good.
                    if (rx_rise) begin
                        state_q        <= StIdle;
                        rx_enable_q    <= 1'b0;
                        ctrl_state_q   <= bus.rx_data;
                        state_valid_q  <= 1'b1;
                        ctrl_present_q <= 1'b1;
                        retry_q        <= '0;
                    end else if (timer_q == TW'(RX_TIMEOUT - 1)) begin
                        state_q     <= StErr;
                        rx_enable_q <= 1'b0;
`ifdef N64_POLL_STATS_EN
                        err_cnt_q   <= sat_inc16(err_cnt_q);
`endif
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                StErr: begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_q      <= retry_q + 1'b1;
                        state_q      <= StTrig;
                        tx_trigger_q <= 1'b1;
                        timer_q      <= '0;
`ifdef N64_POLL_STATS_EN
                        poll_cnt_q   <= sat_inc16(poll_cnt_q);
`endif
                    end else begin
                        state_q        <= StIdle;
                        ctrl_state_q   <= '0;
                        ctrl_present_q <= 1'b0;
                        poll_err_q     <= 1'b1;
                        retry_q        <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.tx_trigger   = tx_trigger_q;
    assign bus.rx_enable    = rx_enable_q;
    assign bus.ctrl_state   = ctrl_state_q;
    assign bus.state_valid  = state_valid_q;
    assign bus.ctrl_present = ctrl_present_q;
    assign bus.poll_err     = poll_err_q;

endmodule

// File: tb/tb_n64_poll_sched.sv
// Directed bench for n64_poll_sched with short test periods; stats checked when
// N64_POLL_STATS_EN is defined.
module tb_n64_poll_sched;
    logic clk_4M = 1'b0;
    logic rst    = 1'b1;

    n64_poll_sched_if bus ();

    n64_poll_sched #(
        .POLL_PERIOD (64),
        .TRIG_LEN    (4),
        .TX_TIMEOUT  (20),
        .RX_TIMEOUT  (40),
        .MAX_RETRY   (2)
    ) u_dut (
        .clk_4M (clk_4M),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_4M = ~clk_4M;

    int n_tests = 0;
    int n_fail  = 0;
    int trig_starts = 0;
    int sv_cnt = 0;
    int perr_cnt = 0;
    logic prev_trig = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n clocks, sampling 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_4M);
            #1;
            if (bus.tx_trigger && !prev_trig) trig_starts++;
            prev_trig = bus.tx_trigger;
            if (bus.state_valid) sv_cnt++;
            if (bus.poll_err) perr_cnt++;
        end
    endtask

    task automatic wait_trig(input int budget, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!bus.tx_trigger && n < budget);
        check_eq("wait_trig", 32'(bus.tx_trigger), 32'd1);
    endtask

    // Entered on the first sampled tx_trigger cycle; returns on the first RXW cycle.
    task automatic to_rxw();
        step(3);
        check_eq("trig_hold", 32'(bus.tx_trigger), 32'd1);
        step(1);
        check_eq("trig_end", 32'(bus.tx_trigger), 32'd0);
        bus.tx_busy = 1'b1;
        step(10);
        check_eq("rxen_txw", 32'(bus.rx_enable), 32'd0);
        bus.tx_busy = 1'b0;
        step(1);
        check_eq("rxen_rxw", 32'(bus.rx_enable), 32'd1);
    endtask

    task automatic reply(input logic [31:0] data, input int delay);
        int sv0;
        step(delay);
        sv0 = sv_cnt;
        bus.rx_data = data;
        bus.rx_done = 1'b1;
        step(1);
        check_eq("sv_pulse", 32'(bus.state_valid), 32'd1);
        check_eq("ctrl_state", bus.ctrl_state, data);
        check_eq("present", 32'(bus.ctrl_present), 32'd1);
        check_eq("rxen_off", 32'(bus.rx_enable), 32'd0);
        bus.rx_done = 1'b0;
        step(1);
        check_eq("sv_once", 32'(sv_cnt - sv0), 32'd1);
    endtask

    initial begin
        int n;
        int t0;
        int p0;
        bus.enable  = 1'b1;
        bus.tx_busy = 1'b0;
        bus.rx_done = 1'b0;
        bus.rx_data = '0;

        // Reset state
        #12;
        check_eq("rst_trig", 32'(bus.tx_trigger), 32'd0);
        check_eq("rst_rxen", 32'(bus.rx_enable), 32'd0);
        check_eq("rst_state", bus.ctrl_state, 32'd0);
        check_eq("rst_present", 32'(bus.ctrl_present), 32'd0);
        check_eq("rst_perr", 32'(bus.poll_err), 32'd0);
`ifdef N64_POLL_STATS_EN
        check_eq("rst_pcnt", 32'(bus.poll_cnt), 32'd0);
        check_eq("rst_ecnt", 32'(bus.err_cnt), 32'd0);
`endif
        step(1);
        rst = 1'b0;
        step(63);
        check_eq("first_trig_63", 32'(bus.tx_trigger), 32'd0);
        step(1);
        check_eq("first_trig_64", 32'(bus.tx_trigger), 32'd1);

        // Good poll
        to_rxw();
        reply(32'h8000_1234, 6);

        // Two missing replies, good on the second retry
        wait_trig(200, n);
        p0 = perr_cnt;
        to_rxw();
        wait_trig(100, n);
        check_eq("rx_timeout_gap", n, 32'd41);
        to_rxw();
        wait_trig(100, n);
        check_eq("rx_timeout_gap2", n, 32'd41);
        check_eq("present_hold", 32'(bus.ctrl_present), 32'd1);
        to_rxw();
        reply(32'h0000_00A5, 3);
        check_eq("no_perr_retry", perr_cnt - p0, 32'd0);

        // No tx_busy at all: three attempts, then poll_err
        wait_trig(200, n);
        t0 = trig_starts;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!bus.poll_err && n < 200);
        check_eq("perr_seen", 32'(bus.poll_err), 32'd1);
        check_eq("perr_latency", n, 32'd75);
        check_eq("retry_trigs", trig_starts - t0, 32'd2);
        check_eq("err_state", bus.ctrl_state, 32'd0);
        check_eq("err_present", 32'(bus.ctrl_present), 32'd0);
        step(1);
        check_eq("perr_pulse", 32'(bus.poll_err), 32'd0);
        // The tick during the retry sequence is dropped.
        wait_trig(200, n);
        check_eq("tick_drop", n, 32'd52);
`ifdef N64_POLL_STATS_EN
        check_eq("pcnt_b", 32'(bus.poll_cnt), 32'd8);
        check_eq("ecnt_b", 32'(bus.err_cnt), 32'd5);
`endif

        // rx_done edge on the RX timeout cycle
        to_rxw();
        step(39);
        t0 = trig_starts;
        p0 = perr_cnt;
        reply(32'hCAFE_0001, 0);
        step(3);
        check_eq("edge_wins_trig", trig_starts - t0, 32'd0);
        check_eq("edge_wins_perr", perr_cnt - p0, 32'd0);
`ifdef N64_POLL_STATS_EN
        check_eq("ecnt_d", 32'(bus.err_cnt), 32'd5);
`endif

        // Enable dropped during RXW
        wait_trig(200, n);
        to_rxw();
        bus.enable = 1'b0;
        reply(32'h1357_2468, 5);
        t0 = trig_starts;
        step(3 * 64 + 8);
        check_eq("disabled_trigs", trig_starts - t0, 32'd0);
        bus.enable = 1'b1;

        // Reset mid-RXW
        wait_trig(200, n);
        to_rxw();
        step(3);
        rst = 1'b1;
        #1;
        check_eq("arst_rxen", 32'(bus.rx_enable), 32'd0);
        check_eq("arst_state", bus.ctrl_state, 32'd0);
        check_eq("arst_present", 32'(bus.ctrl_present), 32'd0);
        check_eq("arst_trig", 32'(bus.tx_trigger), 32'd0);
`ifdef N64_POLL_STATS_EN
        check_eq("arst_pcnt", 32'(bus.poll_cnt), 32'd0);
        check_eq("arst_ecnt", 32'(bus.err_cnt), 32'd0);
`endif
        step(1);
        rst = 1'b0;
        t0 = trig_starts;
        step(63);
        check_eq("rel_trig_63", trig_starts - t0, 32'd0);
        step(1);
        check_eq("rel_trig_64", 32'(bus.tx_trigger), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
